// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by halfword PC,
// with branch-condition evaluation, a registered mispredict pulse and saturating statistics.
module branch_predict_unit #(
    parameter int ENTRIES = 64,
    parameter int PC_W    = 32,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  lookup_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_branch,
    input  logic [PC_W-1:0]  res_pc,
    input  logic [2:0]       res_func3,
    input  logic             s,
    input  logic             z,
    input  logic             c,
    input  logic             v,
    input  logic             res_pred,
    output logic             taken,
    output logic             mispredict,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]       table_r [ENTRIES];
    logic [IDX_W-1:0] lookup_idx_s;
    logic [IDX_W-1:0] res_idx_s;
    logic             cond_s;
    logic             func3_ok_s;
    logic             res_ok_s;
    logic             taken_s;
    logic             mispred_s;
    logic             mispredict_r;
    logic [CNT_W-1:0] branches_r;
    logic [CNT_W-1:0] mispredicts_r;
    logic             unused_s;

    // Counter moves one step toward the resolved direction, pinned at both ends.
    function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic dir);
        logic [1:0] nxt;
        if (dir) begin
            nxt = (cur == 2'b11) ? 2'b11 : cur + 2'b01;
        end else begin
            nxt = (cur == 2'b00) ? 2'b00 : cur - 2'b01;
        end
        return nxt;
    endfunction

    // Statistics counters stop at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cur);
        logic [CNT_W-1:0] nxt;
        if (&cur) begin
            nxt = cur;
        end else begin
            nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Bit 0 is dropped so compressed (halfword-aligned) branches get distinct entries.
    assign lookup_idx_s = lookup_pc[IDX_W:1];
    assign res_idx_s    = res_pc[IDX_W:1];
    assign unused_s     = ^{lookup_pc[PC_W-1:IDX_W+1], lookup_pc[0],
                            res_pc[PC_W-1:IDX_W+1], res_pc[0]};

    // Read the pre-update table contents; a same-cycle update shows up next cycle.
    assign pred_taken = table_r[lookup_idx_s][1];

    // Branch condition decode from the compare flags.
    always_comb begin
        cond_s     = 1'b0;
        func3_ok_s = 1'b1;
        case (res_func3)
            3'b000:  cond_s = z;
            3'b001:  cond_s = ~z;
            3'b100:  cond_s = (s != v);
            3'b101:  cond_s = (s == v);
            3'b110:  cond_s = ~c;
            3'b111:  cond_s = c;
            default: begin
                cond_s     = 1'b0;
                func3_ok_s = 1'b0;
            end
        endcase
    end

    assign res_ok_s  = res_valid & res_branch & func3_ok_s;
    assign taken_s   = res_ok_s & cond_s;
    assign mispred_s = res_ok_s & (taken_s != res_pred);
    assign taken     = taken_s;

    // Prediction table: every entry starts weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i] <= 2'b01;
            end
        end else if (res_ok_s) begin
            table_r[res_idx_s] <= ctr_next(table_r[res_idx_s], taken_s);
        end else begin
            table_r[res_idx_s] <= table_r[res_idx_s];
        end
    end

    // One-cycle mispredict pulse for the resolution seen on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_r <= 1'b0;
        end else begin
            mispredict_r <= mispred_s;
        end
    end

    // Resolved-branch and mispredict statistics; clearing wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branches_r    <= {CNT_W{1'b0}};
            mispredicts_r <= {CNT_W{1'b0}};
        end else if (clr_stats) begin
            branches_r    <= {CNT_W{1'b0}};
            mispredicts_r <= {CNT_W{1'b0}};
        end else begin
            if (res_ok_s) begin
                branches_r <= sat_inc(branches_r);
            end else begin
                branches_r <= branches_r;
            end
            if (mispred_s) begin
                mispredicts_r <= sat_inc(mispredicts_r);
            end else begin
                mispredicts_r <= mispredicts_r;
            end
        end
    end

    assign mispredict       = mispredict_r;
    assign stat_branches    = branches_r;
    assign stat_mispredicts = mispredicts_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with 4-bit statistics counters.
module tb_branch_predict_unit;

    localparam int PC_W  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [PC_W-1:0]  lookup_pc;
    logic             pred_taken;
    logic             res_valid;
    logic             res_branch;
    logic [PC_W-1:0]  res_pc;
    logic [2:0]       res_func3;
    logic             s, z, c, v;
    logic             res_pred;
    logic             taken;
    logic             mispredict;
    logic             clr_stats;
    logic [CNT_W-1:0] stat_branches;
    logic [CNT_W-1:0] stat_mispredicts;

    int tests = 0;
    int fails = 0;

    // {func3, s z c v, expected taken}
    localparam logic [7:0] VECS [12] = '{
        {3'b000, 4'b0100, 1'b1}, {3'b000, 4'b0000, 1'b0},
        {3'b001, 4'b0000, 1'b1}, {3'b001, 4'b0100, 1'b0},
        {3'b100, 4'b1000, 1'b1}, {3'b100, 4'b1001, 1'b0},
        {3'b101, 4'b0000, 1'b1}, {3'b101, 4'b1000, 1'b0},
        {3'b110, 4'b0000, 1'b1}, {3'b110, 4'b0010, 1'b0},
        {3'b111, 4'b0010, 1'b1}, {3'b111, 4'b0000, 1'b0}
    };

    branch_predict_unit #(.ENTRIES(64), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_branch(res_branch), .res_pc(res_pc),
        .res_func3(res_func3), .s(s), .z(z), .c(c), .v(v), .res_pred(res_pred),
        .taken(taken), .mispredict(mispredict), .clr_stats(clr_stats),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_res(input logic [PC_W-1:0] pc, input logic [2:0] f3,
                           input logic [3:0] szcv, input logic pred);
        res_valid  = 1'b1;
        res_branch = 1'b1;
        res_pc     = pc;
        res_func3  = f3;
        {s, z, c, v} = szcv;
        res_pred   = pred;
    endtask

    initial begin
        logic [7:0] vec;
        rst = 1'b1; lookup_pc = 32'h100; res_valid = 1'b0; res_branch = 1'b0;
        res_pc = 32'h0; res_func3 = 3'b000; {s, z, c, v} = 4'b0000;
        res_pred = 1'b0; clr_stats = 1'b0;

        // Reset state
        #2;
        chk("rst_mispredict", mispredict, 0);
        chk("rst_branches", stat_branches, 0);
        chk("rst_mispredicts", stat_mispredicts, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            lookup_pc = i * 2;
            #1;
            chk($sformatf("rst_pred_idx%0d", i), pred_taken, 0);
        end

        // Two taken BEQ resolutions at 0x100, both predicted not-taken
        lookup_pc = 32'h100;
        set_res(32'h100, 3'b000, 4'b0100, 1'b0);
        #1;
        chk("r1_taken", taken, 1);
        chk("r1_pred_before", pred_taken, 0);
        tick();
        chk("r1_mispredict", mispredict, 1);
        chk("r1_pred_after", pred_taken, 1);
        tick();
        chk("r2_mispredict", mispredict, 1);
        chk("r2_pred_after", pred_taken, 1);
        res_valid = 1'b0;
        tick();
        chk("r2_pulse_end", mispredict, 0);
        chk("r2_branches", stat_branches, 2);
        chk("r2_mispredicts", stat_mispredicts, 2);

        // Saturation at strong-taken, then walk back down
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_branches", stat_branches, 0);
        chk("clr_mispredicts", stat_mispredicts, 0);
        set_res(32'h100, 3'b000, 4'b0100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("sat_mispredict%0d", i), mispredict, 0);
            chk($sformatf("sat_pred%0d", i), pred_taken, 1);
        end
        set_res(32'h100, 3'b000, 4'b0000, 1'b1);
        #1;
        chk("nt_taken", taken, 0);
        tick();
        chk("nt1_mispredict", mispredict, 1);
        chk("nt1_pred_weak_taken", pred_taken, 1);
        tick();
        chk("nt2_pred_weak_nt", pred_taken, 0);
        res_valid = 1'b0;
        tick();
        chk("sat_branches", stat_branches, 6);
        chk("sat_mispredicts", stat_mispredicts, 2);

        // Aliasing: 0x180 shares an entry with 0x100, 0x104 does not
        set_res(32'h180, 3'b000, 4'b0100, 1'b0);
        tick();
        res_valid = 1'b0;
        lookup_pc = 32'h100;
        #1;
        chk("alias_shared", pred_taken, 1);
        lookup_pc = 32'h104;
        #1;
        chk("alias_other", pred_taken, 0);

        // Condition sweep, predictions matching so no mispredicts accrue
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        for (int i = 0; i < 12; i++) begin
            vec = VECS[i];
            set_res(32'h202, vec[7:5], vec[4:1], vec[0]);
            #1;
            chk($sformatf("cond_f3_%0b_szcv_%0b", vec[7:5], vec[4:1]), taken, {31'd0, vec[0]});
            tick();
        end
        set_res(32'h202, 3'b010, 4'b1111, 1'b1);
        #1;
        chk("f3_010_taken", taken, 0);
        tick();
        chk("f3_010_mispredict", mispredict, 0);
        set_res(32'h202, 3'b011, 4'b1111, 1'b1);
        #1;
        chk("f3_011_taken", taken, 0);
        tick();
        chk("f3_011_mispredict", mispredict, 0);
        set_res(32'h202, 3'b000, 4'b0100, 1'b0);
        res_branch = 1'b0;
        #1;
        chk("nonbranch_taken", taken, 0);
        tick();
        chk("nonbranch_mispredict", mispredict, 0);
        res_valid = 1'b0;
        tick();
        chk("sweep_branches", stat_branches, 12);
        chk("sweep_mispredicts", stat_mispredicts, 0);

        // Same-index lookup and update in one cycle
        lookup_pc = 32'h40;
        set_res(32'h40, 3'b000, 4'b0100, 1'b0);
        #1;
        chk("bypass_pred_same_cycle", pred_taken, 0);
        chk("bypass_taken", taken, 1);
        tick();
        res_valid = 1'b0;
        chk("bypass_pred_next_cycle", pred_taken, 1);
        chk("bypass_mispredict", mispredict, 1);

        // Statistics saturation with 4-bit counters, then clear beating a resolution
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        set_res(32'h44, 3'b000, 4'b0100, 1'b0);
        repeat (16) tick();
        chk("stat_sat_mispredicts", stat_mispredicts, 15);
        chk("stat_sat_branches", stat_branches, 15);
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        chk("clr_prio_branches", stat_branches, 0);
        chk("clr_prio_mispredicts", stat_mispredicts, 0);
        tick();
        chk("post_clr_branches", stat_branches, 1);
        chk("post_clr_mispredicts", stat_mispredicts, 1);

        // Asynchronous reset in the middle of a resolution
        lookup_pc = 32'h40;
        set_res(32'h46, 3'b000, 4'b0100, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("async_mispredict", mispredict, 0);
        chk("async_branches", stat_branches, 0);
        chk("async_mispredicts", stat_mispredicts, 0);
        chk("async_pred", pred_taken, 0);
        res_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_mispredict", mispredict, 0);
        chk("post_rst_branches", stat_branches, 0);
        lookup_pc = 32'h46;
        #1;
        chk("post_rst_pred_46", pred_taken, 0);
        lookup_pc = 32'h40;
        #1;
        chk("post_rst_pred_40", pred_taken, 0);
        set_res(32'h40, 3'b000, 4'b0100, 1'b1);
        tick();
        res_valid = 1'b0;
        chk("post_rst_weak_nt", pred_taken, 1);
        chk("post_rst_no_mispredict", mispredict, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameter ENTRIES, default 64, SHALL set the number of 2-bit counter entries (power of two, >= 2); IDX_W = log2(ENTRIES).
REQ-002 Parameter PC_W, default 32, SHALL set program-counter width.
REQ-003 Parameter CNT_W, default 16, SHALL set statistics counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 lookup_pc  input  PC_W  fetch-stage PC to predict.
REQ-007 pred_taken  output  1  combinational prediction for lookup_pc.
REQ-008 res_valid  input  1  resolution request valid this cycle.
REQ-009 res_branch  input  1  resolving instruction is a conditional branch.
REQ-010 res_pc  input  PC_W  PC of resolving branch.
REQ-011 res_func3  input  3  branch condition code (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
REQ-012 s, z, c, v  input  1 each  ALU sign, zero, carry, overflow flags of the compare.
REQ-013 res_pred  input  1  prediction issued at fetch for this branch.
REQ-014 taken  output  1  combinational actual branch outcome.
REQ-015 mispredict  output  1  registered one-cycle mispredict pulse.
REQ-016 clr_stats  input  1  synchronous clear of statistics.
REQ-017 stat_branches  output  CNT_W  resolved-branch count.
REQ-018 stat_mispredicts  output  CNT_W  mispredict count.

Function
REQ-019 Index SHALL be pc[IDX_W:1] (halfword granularity for compressed code), for both lookup_pc and res_pc.
REQ-020 Counter encoding SHALL be 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken; pred_taken = table[idx][1].
REQ-021 taken SHALL be: BEQ z; BNE ~z; BLT s!=v; BGE s==v; BLTU ~c; BGEU c; each ANDed with res_valid & res_branch.
REQ-022 func3 010 or 011 SHALL be invalid: taken=0, no table update, no mispredict, no stat increment.
REQ-023 A valid resolution (res_valid & res_branch & valid func3) SHALL update the indexed counter at the next edge: taken -> increment saturating at 11; not taken -> decrement saturating at 00.
REQ-024 Lookup and update of the same index in one cycle SHALL return the pre-update value (no bypass); new value visible the following cycle.
REQ-025 mispredict SHALL be registered: asserted in cycle N+1 for exactly one cycle iff a valid resolution in cycle N had taken != res_pred; back-to-back resolutions yield back-to-back pulses.
REQ-026 stat_branches SHALL increment by 1 per valid resolution; stat_mispredicts SHALL increment with each mispredict condition (same edge as mispredict registers).
REQ-027 Both stat counters SHALL saturate at all-ones, never wrap.
REQ-028 clr_stats SHALL zero both counters at the next edge and take priority over a same-cycle increment.
REQ-029 Aliasing PCs (same index) SHALL share one counter; no tags.

Reset
REQ-030 rst asserted SHALL immediately set every table entry to 01, mispredict to 0, both stat counters to 0, regardless of clock.
REQ-031 A resolution in flight when rst asserts SHALL be discarded; no update after rst deasserts.
REQ-032 pred_taken SHALL read 0 for every index directly after reset.

Verification
REQ-033 Reset, then 2 resolutions at res_pc=0x100 BEQ z=1 res_pred=0 -> first: mispredict pulse next cycle, entry 01->10; second: entry 10->11; pred_taken for lookup_pc=0x100 =1; stat_branches=2, stat_mispredicts=2.
REQ-034 Saturation: 4 taken resolutions then 1 not-taken at same PC -> entry 11 held, then 10; pred_taken stays 1.
REQ-035 Condition table sweep: all 6 func3 with s,z,c,v combinations (e.g. BLT s=1 v=0 -> taken=1; BGEU c=0 -> taken=0); func3=010 -> taken=0, no stat change.
REQ-036 Same-index lookup/update in one cycle (lookup_pc=res_pc=0x40, entry 01, taken) -> pred_taken=0 that cycle, 1 next cycle.
REQ-037 CNT_W=4: 16 mispredicts -> stat_mispredicts holds 15; clr_stats with simultaneous resolution -> both counters 0.
REQ-038 rst asserted mid-cycle between edges during a resolution -> outputs zero immediately, all entries 01 after release, mispredict never pulses.
